// File: rtl/pipe_pkg.sv
// Opcode constants, NOP word, FSM encoding and small decode helpers shared by
// the pipeline hazard controller and its per-stage register-use decoder.
package pipe_pkg;

    localparam logic [5:0]  OP_RTYPE = 6'h00;
    localparam logic [5:0]  OP_LW    = 6'h23;
    localparam logic [5:0]  OP_SW    = 6'h2B;
    localparam logic [5:0]  OP_BEQ   = 6'h04;
    localparam logic [5:0]  OP_J     = 6'h02;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_BAD   = 2'd3
    } state_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] ir);
        return ir[31:26];
    endfunction

    function automatic logic [4:0] rs_of(input logic [31:0] ir);
        return ir[25:21];
    endfunction

    function automatic logic [4:0] rt_of(input logic [31:0] ir);
        return ir[20:16];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] ir);
        return ir[15:11];
    endfunction

endpackage

// File: rtl/inst_reguse.sv
// Decodes one instruction word into the registers it reads and writes.
// A write to $0 is reported as no write, so it can never create a hazard.
module inst_reguse
    import pipe_pkg::*;
(
    input  logic [31:0] ir,
    output logic [4:0]  rd_a,
    output logic        rd_a_vld,
    output logic [4:0]  rd_b,
    output logic        rd_b_vld,
    output logic [4:0]  wr_reg,
    output logic        wr_vld
);

    logic [10:0] unused_bits;

    assign unused_bits = ir[10:0];

    always_comb begin
        rd_a     = rs_of(ir);
        rd_b     = rt_of(ir);
        rd_a_vld = 1'b0;
        rd_b_vld = 1'b0;
        wr_reg   = 5'd0;
        if (ir != NOP_WORD) begin
            case (opcode_of(ir))
                OP_RTYPE: begin
                    rd_a_vld = 1'b1;
                    rd_b_vld = 1'b1;
                    wr_reg   = rd_of(ir);
                end
                OP_LW: begin
                    rd_a_vld = 1'b1;
                    wr_reg   = rt_of(ir);
                end
                OP_SW, OP_BEQ: begin
                    rd_a_vld = 1'b1;
                    rd_b_vld = 1'b1;
                end
                OP_J:    wr_reg = 5'd0;
                default: wr_reg = 5'd0;
            endcase
        end
        wr_vld = (wr_reg != 5'd0);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: stalls on RAW hazards, flushes on
// MA-stage redirects, and counts both kinds of event with saturating counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 16
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_ir,
    input  logic [31:0]      ex_ir,
    input  logic [31:0]      ma_ir,
    input  logic [31:0]      wb_ir,
    input  logic             pc_src,
    output logic             pc_we,
    output logic             fiid_we,
    output logic             fiid_flush,
    output logic             idex_flush,
    output logic             exma_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [31:0] stage_ir [4];
    logic [4:0]  rd_a     [4];
    logic        rd_a_vld [4];
    logic [4:0]  rd_b     [4];
    logic        rd_b_vld [4];
    logic [4:0]  wr_reg   [4];
    logic        wr_vld   [4];

    logic   hit_ex, hit_ma, hit_wb, raw_hit;
    logic   stall_evt, flush_evt;
    state_t state_q, state_nxt;
    logic   unused_dec;

    function automatic logic reads_reg(input logic a_vld, input logic [4:0] a,
                                       input logic b_vld, input logic [4:0] b,
                                       input logic w_vld, input logic [4:0] w);
        return w_vld && ((a_vld && (a == w)) || (b_vld && (b == w)));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign stage_ir[0] = id_ir;
    assign stage_ir[1] = ex_ir;
    assign stage_ir[2] = ma_ir;
    assign stage_ir[3] = wb_ir;

    // index 0 is the consumer in ID; 1..3 are the producers in EX, MA, WB
    for (genvar i = 0; i < 4; i++) begin : g_dec
        inst_reguse u_dec (
            .ir       (stage_ir[i]),
            .rd_a     (rd_a[i]),
            .rd_a_vld (rd_a_vld[i]),
            .rd_b     (rd_b[i]),
            .rd_b_vld (rd_b_vld[i]),
            .wr_reg   (wr_reg[i]),
            .wr_vld   (wr_vld[i])
        );
    end

    assign unused_dec = ^{wr_reg[0], wr_vld[0],
                          rd_a[1], rd_a_vld[1], rd_b[1], rd_b_vld[1],
                          rd_a[2], rd_a_vld[2], rd_b[2], rd_b_vld[2],
                          rd_a[3], rd_a_vld[3], rd_b[3], rd_b_vld[3]};

    assign hit_ex  = reads_reg(rd_a_vld[0], rd_a[0], rd_b_vld[0], rd_b[0], wr_vld[1], wr_reg[1]);
    assign hit_ma  = reads_reg(rd_a_vld[0], rd_a[0], rd_b_vld[0], rd_b[0], wr_vld[2], wr_reg[2]);
    // with a bypassing register file the WB producer is already visible to ID
    assign hit_wb  = (WB_BYPASS == 1'b0) &&
                     reads_reg(rd_a_vld[0], rd_a[0], rd_b_vld[0], rd_b[0], wr_vld[3], wr_reg[3]);
    assign raw_hit = hit_ex | hit_ma | hit_wb;

    always_comb begin
        pc_we      = 1'b1;
        fiid_we    = 1'b1;
        fiid_flush = 1'b0;
        idex_flush = 1'b0;
        exma_flush = 1'b0;
        state_nxt  = ST_RUN;
        stall_evt  = 1'b0;
        flush_evt  = 1'b0;
        if (reset) begin
            case (state_q)
                ST_RUN, ST_STALL: begin
                    if (pc_src) begin
                        fiid_flush = 1'b1;
                        idex_flush = 1'b1;
                        exma_flush = 1'b1;
                        state_nxt  = ST_FLUSH;
                        flush_evt  = 1'b1;
                    end else if (raw_hit) begin
                        pc_we      = 1'b0;
                        fiid_we    = 1'b0;
                        idex_flush = 1'b1;
                        state_nxt  = ST_STALL;
                        stall_evt  = 1'b1;
                    end
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q <= state_nxt;
            if (stall_evt) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (flush_evt) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances (bypass, no bypass, narrow
// counters) share stimulus and are compared against a register-mask model.
module tb_pipe_hazard_ctrl;

    localparam logic [31:0] ADD_3_1_2 = 32'h0022_1820;
    localparam logic [31:0] LW_1      = 32'h8C01_0000;
    localparam logic [31:0] ADD_0_1_2 = 32'h0022_0020;
    localparam logic [31:0] ADD_5_0_0 = 32'h0000_2820;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] id_ir, ex_ir, ma_ir, wb_ir;
    logic        pc_src;

    logic        a_pc_we, a_fiid_we, a_fiid_flush, a_idex_flush, a_exma_flush;
    logic [1:0]  a_state;
    logic [15:0] a_scnt, a_fcnt;
    logic        b_pc_we, b_fiid_we, b_fiid_flush, b_idex_flush, b_exma_flush;
    logic [1:0]  b_state;
    logic [15:0] b_scnt, b_fcnt;
    logic        c_pc_we, c_fiid_we, c_fiid_flush, c_idex_flush, c_exma_flush;
    logic [1:0]  c_state;
    logic [2:0]  c_scnt, c_fcnt;

    int n_cmp = 0;
    int n_bad = 0;
    int ms  [3];
    int msc [3];
    int mfc [3];
    int cmax [3] = '{65535, 65535, 7};
    bit byp  [3] = '{1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.WB_BYPASS(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .id_ir(id_ir), .ex_ir(ex_ir), .ma_ir(ma_ir), .wb_ir(wb_ir),
        .pc_src(pc_src), .pc_we(a_pc_we), .fiid_we(a_fiid_we), .fiid_flush(a_fiid_flush),
        .idex_flush(a_idex_flush), .exma_flush(a_exma_flush), .state(a_state),
        .stall_cnt(a_scnt), .flush_cnt(a_fcnt));

    pipe_hazard_ctrl #(.WB_BYPASS(1'b0), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .id_ir(id_ir), .ex_ir(ex_ir), .ma_ir(ma_ir), .wb_ir(wb_ir),
        .pc_src(pc_src), .pc_we(b_pc_we), .fiid_we(b_fiid_we), .fiid_flush(b_fiid_flush),
        .idex_flush(b_idex_flush), .exma_flush(b_exma_flush), .state(b_state),
        .stall_cnt(b_scnt), .flush_cnt(b_fcnt));

    pipe_hazard_ctrl #(.WB_BYPASS(1'b1), .CNT_W(3)) dut_c (
        .clk(clk), .reset(reset), .id_ir(id_ir), .ex_ir(ex_ir), .ma_ir(ma_ir), .wb_ir(wb_ir),
        .pc_src(pc_src), .pc_we(c_pc_we), .fiid_we(c_fiid_we), .fiid_flush(c_fiid_flush),
        .idex_flush(c_idex_flush), .exma_flush(c_exma_flush), .state(c_state),
        .stall_cnt(c_scnt), .flush_cnt(c_fcnt));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] obs_ctl(input int k);
        case (k)
            0:       return {a_pc_we, a_fiid_we, a_fiid_flush, a_idex_flush, a_exma_flush};
            1:       return {b_pc_we, b_fiid_we, b_fiid_flush, b_idex_flush, b_exma_flush};
            default: return {c_pc_we, c_fiid_we, c_fiid_flush, c_idex_flush, c_exma_flush};
        endcase
    endfunction

    function automatic logic [1:0] obs_state(input int k);
        case (k)
            0:       return a_state;
            1:       return b_state;
            default: return c_state;
        endcase
    endfunction

    function automatic logic [15:0] obs_scnt(input int k);
        case (k)
            0:       return a_scnt;
            1:       return b_scnt;
            default: return {13'd0, c_scnt};
        endcase
    endfunction

    function automatic logic [15:0] obs_fcnt(input int k);
        case (k)
            0:       return a_fcnt;
            1:       return b_fcnt;
            default: return {13'd0, c_fcnt};
        endcase
    endfunction

    // set of architectural registers an instruction reads, one bit per register
    function automatic logic [31:0] rmask(input logic [31:0] ir);
        logic [31:0] m;
        m = 32'd0;
        case (ir[31:26])
            6'h00, 6'h2B, 6'h04: m = (32'd1 << ir[25:21]) | (32'd1 << ir[20:16]);
            6'h23:               m = 32'd1 << ir[25:21];
            default:             m = 32'd0;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] wmask(input logic [31:0] ir);
        logic [31:0] m;
        m = 32'd0;
        case (ir[31:26])
            6'h00:   m = 32'd1 << ir[15:11];
            6'h23:   m = 32'd1 << ir[20:16];
            default: m = 32'd0;
        endcase
        return m & ~32'd1;
    endfunction

    function automatic bit hazard(input int k);
        logic [31:0] w;
        w = wmask(ex_ir) | wmask(ma_ir) | (byp[k] ? 32'd0 : wmask(wb_ir));
        return (rmask(id_ir) & w) != 32'd0;
    endfunction

    task automatic model_eval(input int k, output logic [4:0] ctl, output int nxt,
                              output bit sev, output bit fev);
        ctl = 5'b11000;
        nxt = 0;
        sev = 1'b0;
        fev = 1'b0;
        if (reset === 1'b1 && ms[k] != 2) begin
            if (pc_src) begin
                ctl = 5'b11111; nxt = 2; fev = 1'b1;
            end else if (hazard(k)) begin
                ctl = 5'b00010; nxt = 1; sev = 1'b1;
            end
        end
    endtask

    task automatic step(input string tag);
        logic [4:0] ctl;
        int         nxt;
        bit         sev, fev;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            model_eval(k, ctl, nxt, sev, fev);
            check($sformatf("%s.u%0d.ctl", tag, k),   32'(obs_ctl(k)),   32'(ctl));
            check($sformatf("%s.u%0d.state", tag, k), 32'(obs_state(k)), 32'(ms[k]));
            check($sformatf("%s.u%0d.scnt", tag, k),  32'(obs_scnt(k)),  32'(msc[k]));
            check($sformatf("%s.u%0d.fcnt", tag, k),  32'(obs_fcnt(k)),  32'(mfc[k]));
        end
        @(posedge clk);
        if (reset === 1'b1) begin
            for (int k = 0; k < 3; k++) begin
                model_eval(k, ctl, nxt, sev, fev);
                ms[k] = nxt;
                if (sev && msc[k] < cmax[k]) msc[k]++;
                if (fev && mfc[k] < cmax[k]) mfc[k]++;
            end
        end
        #1;
    endtask

    function automatic logic [31:0] rand_ir();
        logic [5:0] op;
        case ($urandom_range(0, 6))
            0:       op = 6'h00;
            1:       op = 6'h23;
            2:       op = 6'h2B;
            3:       op = 6'h04;
            4:       op = 6'h02;
            5:       op = 6'h0F;
            default: return 32'h0;
        endcase
        return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'd0, 6'h20};
    endfunction

    initial begin
        reset  = 1'b0;
        id_ir  = 32'h0;
        ex_ir  = 32'h0;
        ma_ir  = 32'h0;
        wb_ir  = 32'h0;
        pc_src = 1'b0;
        #1;
        check("rst.state", 32'(a_state), 32'd0);
        check("rst.pc_we", 32'(a_pc_we), 32'd1);
        check("rst.scnt",  32'(a_scnt),  32'd0);
        check("rst.fcnt",  32'(a_fcnt),  32'd0);
        step("reset");
        reset = 1'b1;

        // producer writes $0, consumer reads $0: never a hazard
        id_ir = ADD_5_0_0;
        ex_ir = ADD_0_1_2;
        step("zero_reg");
        check("zero_reg.a.state", 32'(a_state), 32'd0);
        check("zero_reg.a.scnt",  32'(a_scnt),  32'd0);
        check("zero_reg.b.scnt",  32'(b_scnt),  32'd0);

        // lw $1 walks EX -> MA -> WB under add $3,$1,$2 held in ID
        id_ir = ADD_3_1_2;
        ex_ir = LW_1;
        step("raw_ex");
        check("raw_ex.a.state", 32'(a_state),      32'd1);
        check("raw_ex.a.scnt",  32'(a_scnt),       32'd1);
        check("raw_ex.a.pc_we", 32'(a_pc_we),      32'd0);
        check("raw_ex.a.idexf", 32'(a_idex_flush), 32'd1);
        ex_ir = 32'h0;
        ma_ir = LW_1;
        step("raw_ma");
        check("raw_ma.a.state", 32'(a_state), 32'd1);
        check("raw_ma.a.scnt",  32'(a_scnt),  32'd2);
        ma_ir = 32'h0;
        wb_ir = LW_1;
        step("raw_wb");
        check("raw_wb.a.state", 32'(a_state), 32'd0);
        check("raw_wb.a.scnt",  32'(a_scnt),  32'd2);
        check("raw_wb.b.state", 32'(b_state), 32'd1);
        check("raw_wb.b.scnt",  32'(b_scnt),  32'd3);

        // redirect while stalled
        wb_ir = 32'h0;
        ex_ir = LW_1;
        step("pre_redirect");
        pc_src = 1'b1;
        #1;
        check("redirect.a.ctl", 32'({a_pc_we, a_fiid_flush, a_idex_flush, a_exma_flush}), 32'hF);
        step("redirect");
        check("redirect.a.state", 32'(a_state), 32'd2);
        check("redirect.a.fcnt",  32'(a_fcnt),  32'd1);
        pc_src = 1'b0;
        step("post_flush");
        check("post_flush.a.state", 32'(a_state), 32'd0);
        check("post_flush.a.fcnt",  32'(a_fcnt),  32'd1);

        for (int i = 0; i < 300; i++) begin
            id_ir  = rand_ir();
            ex_ir  = rand_ir();
            ma_ir  = rand_ir();
            wb_ir  = rand_ir();
            pc_src = ($urandom_range(0, 4) == 0);
            step("rand");
        end

        // narrow counter must stick at all-ones through a long stall
        id_ir  = ADD_3_1_2;
        ex_ir  = LW_1;
        ma_ir  = 32'h0;
        wb_ir  = 32'h0;
        pc_src = 1'b0;
        for (int i = 0; i < 10; i++) step("sat");
        check("sat.c.scnt",  32'(c_scnt),  32'd7);
        check("sat.a.state", 32'(a_state), 32'd1);

        // asynchronous reset in the middle of a stall cycle
        #2;
        reset = 1'b0;
        #1;
        check("arst.a.state", 32'(a_state), 32'd0);
        check("arst.a.pc_we", 32'(a_pc_we), 32'd1);
        check("arst.a.idexf", 32'(a_idex_flush), 32'd0);
        check("arst.a.scnt",  32'(a_scnt),  32'd0);
        check("arst.a.fcnt",  32'(a_fcnt),  32'd0);
        check("arst.b.state", 32'(b_state), 32'd0);
        check("arst.c.scnt",  32'(c_scnt),  32'd0);
        for (int k = 0; k < 3; k++) begin
            ms[k]  = 0;
            msc[k] = 0;
            mfc[k] = 0;
        end
        step("in_reset");
        reset = 1'b1;
        step("release");
        check("release.a.state", 32'(a_state), 32'd1);
        check("release.a.scnt",  32'(a_scnt),  32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: WB_BYPASS, 1, register file forwards same-cycle write data to reads, so a WB-stage producer causes no stall.
REQ-002 Parameter: CNT_W, 16, width of the stall and flush event counters.
REQ-003 clk  in  1  single clock for the block; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 id_ir  in  32  FIID instruction register output.
REQ-006 ex_ir  in  32  IDEX instruction register output.
REQ-007 ma_ir  in  32  EXMA instruction register output.
REQ-008 wb_ir  in  32  MAWB instruction register output.
REQ-009 pc_src  in  1  taken branch or jump resolved in the MA stage, (ZF & Branch) | Jump.
REQ-010 pc_we  out  1  PC load enable.
REQ-011 fiid_we  out  1  FIID load enable.
REQ-012 fiid_flush  out  1  load NOP (32'h0) into FIID.
REQ-013 idex_flush  out  1  load NOP into IDEX (bubble or squash).
REQ-014 exma_flush  out  1  load NOP into EXMA.
REQ-015 state  out  2  current FSM state, for debug.
REQ-016 stall_cnt  out  CNT_W  count of stall cycles.
REQ-017 flush_cnt  out  CNT_W  count of redirect events.

Function
REQ-018 Decode per stage: opcode 0x00 (R) reads rs,rt, writes rd; 0x23 (lw) reads rs, writes rt; 0x2B (sw) and 0x04 (beq) read rs,rt, write none; 0x02 (j) and all other opcodes read none, write none.
REQ-019 A write to register 0 and the all-zero word shall never produce a hazard.
REQ-020 raw_hit: any register read by id_ir equals a nonzero destination of ex_ir or ma_ir, or of wb_ir when WB_BYPASS=0.
REQ-021 The FSM states are RUN=0, STALL=1, FLUSH=2; the encoding 3 is illegal and returns to RUN on the next edge.
REQ-022 In RUN or STALL, pc_src=1 gives priority over raw_hit: pc_we=1, fiid_flush=idex_flush=exma_flush=1, fiid_we=1, and next state FLUSH.
REQ-023 In RUN or STALL, raw_hit=1 with pc_src=0 gives pc_we=0, fiid_we=0, idex_flush=1, and next state STALL.
REQ-024 With neither condition, pc_we=fiid_we=1, all flushes are 0, and next state RUN.
REQ-025 FLUSH lasts exactly one cycle: outputs as in REQ-024, pc_src and raw_hit ignored, next state RUN.
REQ-026 Hazard and flush outputs are combinational from the current state and inputs, for same-cycle effect; state and counters are registered.
REQ-027 stall_cnt increments on every edge where REQ-023 applies; flush_cnt increments on every edge where REQ-022 applies.
REQ-028 Both counters saturate at all-ones and never wrap.
REQ-029 A stall ends in the first cycle raw_hit is 0; multi-cycle stalls are counted once per cycle.

Reset
REQ-030 While reset=0: state=RUN and stall_cnt=flush_cnt=0, with outputs as in REQ-024 (pc_we=1, fiid_we=1, flushes 0).
REQ-031 Reset asserted during STALL or FLUSH aborts the state immediately, with no pending flush retained.
REQ-032 The first edge after release evaluates from RUN.

Structure
REQ-033 A shared package pipe_pkg shall hold: opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J; NOP_WORD; and the state encoding.
REQ-034 One sub-module, inst_reguse, shall decode a 32-bit word into rd_a, rd_b, wr_reg and their valid bits, instantiated once per stage.

Verification
REQ-035 id_ir=add $3,$1,$2 and ex_ir=lw $1,0($0), pc_src=0 -> pc_we=0, idex_flush=1, state=STALL, stall_cnt=1 after the edge.
REQ-036 Same case with WB_BYPASS=1: the producer advances EX->MA->WB -> 2 stall cycles, then RUN with stall_cnt=2.
REQ-037 pc_src=1 during STALL -> all three flushes =1 and pc_we=1, state FLUSH, then RUN; flush_cnt=1.
REQ-038 Producer writes $0 (add $0,$1,$2 in EX) with consumer reading $0 -> no stall, stall_cnt=0.
REQ-039 Preload stall_cnt to 16'hFFFE with 3 stall cycles -> counter holds at 16'hFFFF.
REQ-040 reset=0 mid-STALL -> state=0, pc_we=1, counters 0 asynchronously, before the next clk edge.
